// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch / length-decode stage.
// The IFETCH_ILLEGAL_TRAP_EN build option is handled in instruction_fetch.sv.
package ifetch_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned LEN_W = 3;
    localparam int unsigned HI_W  = 24;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    localparam logic [7:0] OP_PUSH_EBP   = 8'h55;
    localparam logic [7:0] OP_POP_EBP    = 8'h5D;
    localparam logic [7:0] OP_RET        = 8'hC3;
    localparam logic [7:0] OP_LEAVE      = 8'hC9;
    localparam logic [7:0] OP_PUSH_IMM8  = 8'h6A;
    localparam logic [7:0] OP_MOV_RM_R   = 8'h89;
    localparam logic [7:0] OP_MOV_R_RM   = 8'h8B;
    localparam logic [7:0] OP_GRP1_IMM8  = 8'h83;
    localparam logic [7:0] OP_CALL_REL32 = 8'hE8;

    localparam logic [1:0] MOD_DISP8 = 2'b01;
    localparam logic [1:0] MOD_REG   = 2'b11;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        FETCH_HI = 2'd1,
        HALT     = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [7:0]       opcode;
        logic [7:0]       modrm;
        logic [XLEN-1:0]  imm;
        logic [LEN_W-1:0] len;
    } inst_rec_t;

    function automatic logic [XLEN-1:0] sext8(input logic [7:0] b);
        return {{(XLEN-8){b[7]}}, b};
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Bundle of program-memory, instruction-record and redirect signals of the fetch stage.
interface ifetch_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [7:0]  inst_opcode;
    logic [7:0]  inst_modrm;
    logic [31:0] inst_imm;
    logic [2:0]  inst_len;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_halted;

    modport master (
        output mem_addr, inst_valid, inst_pc, inst_opcode, inst_modrm,
               inst_imm, inst_len, fetch_halted,
        input  mem_data, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_addr, inst_valid, inst_pc, inst_opcode, inst_modrm,
               inst_imm, inst_len, fetch_halted,
        output mem_data, inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ifetch_len_decode.sv
// Combinational length decoder: classifies the 4-byte window starting at the opcode byte.
module ifetch_len_decode
    import ifetch_pkg::*;
(
    input  logic [XLEN-1:0]  window_i,
    output logic             legal_c_o,
    output logic [LEN_W-1:0] len_c_o,
    output logic             needs_hi_c_o,
    output logic [7:0]       modrm_c_o,
    output logic [XLEN-1:0]  imm_c_o
);

    logic [7:0] b0, b1, b2, b3;

    assign b0 = window_i[31:24];
    assign b1 = window_i[23:16];
    assign b2 = window_i[15:8];
    assign b3 = window_i[7:0];

    // For E8 only the low three rel32 bytes are visible here; the top adds byte 4.
    always_comb begin
        legal_c_o    = 1'b1;
        len_c_o      = LEN_W'(1);
        needs_hi_c_o = 1'b0;
        modrm_c_o    = 8'h00;
        imm_c_o      = '0;
        case (b0)
            OP_PUSH_EBP, OP_POP_EBP, OP_RET, OP_LEAVE: ;
            OP_PUSH_IMM8: begin
                len_c_o = LEN_W'(2);
                imm_c_o = sext8(b1);
            end
            OP_MOV_RM_R, OP_MOV_R_RM: begin
                if (b1[7:6] == MOD_REG) begin
                    modrm_c_o = b1;
                    len_c_o   = LEN_W'(2);
                end else if (b1[7:6] == MOD_DISP8) begin
                    modrm_c_o = b1;
                    len_c_o   = LEN_W'(3);
                    imm_c_o   = sext8(b2);
                end else begin
                    legal_c_o = 1'b0;
                end
            end
            OP_GRP1_IMM8: begin
                if (b1[7:6] == MOD_REG) begin
                    modrm_c_o = b1;
                    len_c_o   = LEN_W'(3);
                    imm_c_o   = sext8(b2);
                end else begin
                    legal_c_o = 1'b0;
                end
            end
            OP_CALL_REL32: begin
                len_c_o      = LEN_W'(5);
                needs_hi_c_o = 1'b1;
                imm_c_o      = {8'h00, b3, b2, b1};
            end
            default: legal_c_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, fetch FSM and single-entry instruction record slot.
// Build option IFETCH_ILLEGAL_TRAP_EN: illegal opcodes park the stage in HALT.
module instruction_fetch
    import ifetch_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    ifetch_if.master fetch_if
);

`ifdef IFETCH_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic            valid_q, valid_d;
    inst_rec_t       rec_q, rec_d;
    logic [HI_W-1:0] hi_q, hi_d;

    logic             dec_legal;
    logic [LEN_W-1:0] dec_len;
    logic             dec_needs_hi;
    logic [7:0]       dec_modrm;
    logic [XLEN-1:0]  dec_imm;
    logic             slot_free_c;
    logic             emit_c;

    ifetch_len_decode u_len_decode (
        .window_i     (fetch_if.mem_data),
        .legal_c_o    (dec_legal),
        .len_c_o      (dec_len),
        .needs_hi_c_o (dec_needs_hi),
        .modrm_c_o    (dec_modrm),
        .imm_c_o      (dec_imm)
    );

    assign slot_free_c = !valid_q || fetch_if.inst_ready;
    assign emit_c      = !dec_needs_hi && (dec_legal || !TRAP_EN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Next state; redirect outranks everything, including HALT.
    always_comb begin
        state_d = state_q;
        if (fetch_if.redirect_valid) begin
            state_d = FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (slot_free_c && dec_needs_hi) state_d = FETCH_HI;
`ifdef IFETCH_ILLEGAL_TRAP_EN
                    else if (slot_free_c && !dec_legal) state_d = HALT;
`endif
                end
                FETCH_HI: if (slot_free_c) state_d = FETCH;
`ifdef IFETCH_ILLEGAL_TRAP_EN
                HALT: state_d = HALT;
`endif
                default: state_d = FETCH;
            endcase
        end
    end

    // Datapath next values; an accepted record drains the slot unless refilled.
    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q && !fetch_if.inst_ready;
        rec_d   = rec_q;
        hi_d    = hi_q;
        if (fetch_if.redirect_valid) begin
            pc_d    = fetch_if.redirect_pc;
            valid_d = 1'b0;
            hi_d    = '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (slot_free_c && dec_needs_hi) begin
                        hi_d = dec_imm[HI_W-1:0];
                    end else if (slot_free_c && emit_c) begin
                        rec_d.pc     = pc_q;
                        rec_d.opcode = fetch_if.mem_data[31:24];
                        rec_d.modrm  = dec_modrm;
                        rec_d.imm    = dec_imm;
                        rec_d.len    = dec_len;
                        valid_d      = 1'b1;
                        pc_d         = pc_q + XLEN'(dec_len);
                    end
                end
                FETCH_HI: begin
                    if (slot_free_c) begin
                        rec_d.pc     = pc_q;
                        rec_d.opcode = OP_CALL_REL32;
                        rec_d.modrm  = 8'h00;
                        rec_d.imm    = {fetch_if.mem_data[31:24], hi_q};
                        rec_d.len    = LEN_W'(5);
                        valid_d      = 1'b1;
                        pc_d         = pc_q + 32'd5;
                    end
                end
                default: ;
            endcase
        end
        mem_addr_d = (state_d == FETCH_HI) ? pc_d + 32'd4 : pc_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            mem_addr_q <= RESET_PC;
            valid_q    <= 1'b0;
            rec_q      <= '0;
            hi_q       <= '0;
        end else begin
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            valid_q    <= valid_d;
            rec_q      <= rec_d;
            hi_q       <= hi_d;
        end
    end

`ifdef IFETCH_ILLEGAL_TRAP_EN
    logic halted_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) halted_q <= 1'b0;
        else       halted_q <= (state_d == HALT);
    end

    assign fetch_if.fetch_halted = halted_q;
`else
    assign fetch_if.fetch_halted = 1'b0;
`endif

    assign fetch_if.mem_addr    = mem_addr_q;
    assign fetch_if.inst_valid  = valid_q;
    assign fetch_if.inst_pc     = rec_q.pc;
    assign fetch_if.inst_opcode = rec_q.opcode;
    assign fetch_if.inst_modrm  = rec_q.modrm;
    assign fetch_if.inst_imm    = rec_q.imm;
    assign fetch_if.inst_len    = rec_q.len;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch and length-decode stage between the combinational byte-addressed program memory and the execute stage. Drives the fetch address and consumes the 32-bit, 4-byte window returned for it. Recognises the supported IA-32 opcode subset, assembles 1–5 byte instructions (using a second window read when needed), and hands decoded instruction records downstream over a valid/ready handshake. Accepts PC redirects from execute for call, ret and jumps.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- mem_addr  out  32  program memory byte address
- mem_data  in  32  window at mem_addr; byte mem_addr+0 in [31:24], +1 in [23:16], +2 in [15:8], +3 in [7:0]
- inst_valid  out  1  instruction record valid
- inst_ready  in  1  execute accepts record
- inst_pc  out  32  address of opcode byte
- inst_opcode  out  8  opcode byte
- inst_modrm  out  8  ModRM byte; 0 if absent
- inst_imm  out  32  imm8/disp8 sign-extended, or rel32; 0 if absent
- inst_len  out  3  length in bytes, 1–5
- redirect_valid  in  1  load redirect_pc, flush
- redirect_pc  in  32  new fetch PC
- fetch_halted  out  1  in HALT state (only with trap feature)

## Operation
- Length table: 55, 5D, C3, C9 → 1; 6A ib → 2; 89/8B with mod=11 → 2, mod=01 → 3 (disp8); 83 ib with mod=11 → 3; E8 rel32 → 5. Anything else, including 89/8B/83 with other mod values, is illegal.
- rel32 is little-endian: imm = {b4,b3,b2,b1}.
- States:
  - FETCH: mem_addr=pc. If the output slot is free (not valid, or valid&&ready), decode the window.
    - len≤4: register the record, pc←pc+len, stay.
    - E8: capture b1..b3, go to FETCH_HI.
  - FETCH_HI: mem_addr=pc+4. Take b4=mem_data[31:24]. When the slot is free, register the record, pc←pc+5, go to FETCH.
  - HALT: inst_valid=0, mem_addr=pc, fetch_halted=1.
- Output slot is one register. A held record stays stable while inst_valid&&!inst_ready; fetch stalls.
- Redirect has highest priority in every state, including HALT. On that edge: pc←redirect_pc, inst_valid←0, FETCH_HI captured bytes discarded, state←FETCH. The record in the slot that cycle is dropped even if inst_ready=1.
- PC arithmetic is modulo 2^32, with no bounds check.

## Timing
- Reset values: pc=RESET_PC, state=FETCH, inst_valid=0, all inst_* fields 0, fetch_halted=0, mem_addr=RESET_PC.
- First record is valid after the first rising edge following reset deassertion.
- Throughput with inst_ready held high:
  - one instruction per cycle for len≤4;
  - E8 occupies 2 cycles.
- Redirect at edge N: first record from redirect_pc is valid after edge N+1.
- Reset asserted mid-E8 or mid-stall: immediate return to reset values; no partial record is emitted.

## Configuration
- IFETCH_ILLEGAL_TRAP_EN defined:
  - an illegal opcode in FETCH moves to HALT; no record is emitted and pc stays at the illegal byte;
  - only redirect or reset exits HALT.
- Undefined:
  - an illegal opcode is emitted as a 1-byte record (modrm=0, imm=0), pc←pc+1;
  - fetch_halted is tied 0 and HALT is absent.

## Structure
- Package ifetch_pkg holds:
  - opcode localparams (OP_PUSH_EBP=8'h55, OP_POP_EBP=8'h5D, OP_RET=8'hC3, OP_LEAVE=8'hC9, OP_PUSH_IMM8=8'h6A, OP_MOV_RM_R=8'h89, OP_MOV_R_RM=8'h8B, OP_GRP1_IMM8=8'h83, OP_CALL_REL32=8'hE8);
  - the state enum (FETCH, FETCH_HI, HALT);
  - the ModRM mod field constants.
- Sub-module ifetch_len_decode: combinational, window in → {legal, len, needs_hi, modrm, imm_partial}. The instruction_fetch top holds the PC, the FSM and the output register.

## Test plan
- Window stream 55 89 E5 8B 45 08 83 E8 01 5D C3 with ready=1 → records at pc 0,1,3,6,9,10 with lengths 1,2,3,3,1,1; rec@3 imm=32'h8, rec@6 imm=32'h1.
- E8 EB FF FF FF at pc 16 → record after 2 cycles: len=5, imm=32'hFFFF_FFEB; next pc=21; mem_addr=20 during FETCH_HI.
- 6A 0A with inst_ready=0 for 3 cycles → record (imm=32'hA) held stable; pc and mem_addr unchanged until the accept.
- redirect_valid=1 to 32'h0B during FETCH_HI of an E8 at pc 16 → E8 record never appears; next record pc=0x0B.
- Opcode 8'hFF at pc 4:
  - with the trap macro: no record, fetch_halted=1, mem_addr=4; a redirect to 0 resumes fetch;
  - without: 1-byte record opcode=FF, next pc=5.
- reset pulse while a record is held → inst_valid=0 and pc=RESET_PC immediately; first record after deassertion comes from RESET_PC.
